// File: rtl/bit_stream_deserializer.sv
// bit_stream_deserializer
//
// Collects a serial bit stream into WIDTH-bit parallel words. A word ends when
// WIDTH bits have arrived or when data_last_i is seen with a valid bit. Any
// bit positions not written before an early end stay zero. The output word
// therefore carries no extra ones into the population counter that follows.
//
// Parameters:
//   WIDTH     - parallel output word width in bits (>= 2)
//   MSB_FIRST - 1: first received bit goes to bit WIDTH-1
//               0: first received bit goes to bit 0
//
// Ports:
//   clk_i            - clock, all logic on the rising edge
//   arst_i           - asynchronous active-high reset
//   data_i           - serial data bit
//   data_val_i       - data_i is valid this cycle
//   data_last_i      - final bit of the current word (qualified by data_val_i)
//   deser_data_o     - assembled word, held until the next completion
//   deser_len_o      - number of received bits in deser_data_o (1..WIDTH)
//   deser_data_val_o - one-cycle pulse marking a new deser_data_o/deser_len_o
//   busy_o           - a partial word is in progress
module bit_stream_deserializer #(
  parameter int WIDTH     = 24,
  parameter int MSB_FIRST = 1
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  input  logic                       data_i,
  input  logic                       data_val_i,
  input  logic                       data_last_i,
  output logic [WIDTH-1:0]           deser_data_o,
  output logic [$clog2(WIDTH+1)-1:0] deser_len_o,
  output logic                       deser_data_val_o,
  output logic                       busy_o
);

  localparam int CW = $clog2(WIDTH);
  localparam int LW = $clog2(WIDTH+1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] asm_q;
  logic [CW-1:0]    pos;
  logic [WIDTH-1:0] asm_with_bit;
  logic             complete;

  // Position of the incoming bit and the word as it would look with that bit
  // merged in. The merged value feeds both the output register (on
  // completion) and the assembly register (otherwise).
  always_comb begin
    pos          = cnt;
    asm_with_bit = asm_q;
    if (MSB_FIRST != 0) begin
      pos = CW'(WIDTH-1) - cnt;
    end
    asm_with_bit[pos] = data_i;
    complete = (cnt == CW'(WIDTH-1)) || data_last_i;
  end

  // Counter and assembly register. On completion both clear, so a valid bit
  // in the very next cycle starts a fresh word with no bubble.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt   <= '0;
      asm_q <= '0;
    end else if (data_val_i) begin
      if (complete) begin
        cnt   <= '0;
        asm_q <= '0;
      end else begin
        cnt   <= cnt + CW'(1);
        asm_q <= asm_with_bit;
      end
    end
  end

  // Output registers. The data/length pair holds between completions while
  // the valid flag is a single-cycle pulse.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      deser_data_o     <= '0;
      deser_len_o      <= '0;
      deser_data_val_o <= 1'b0;
    end else begin
      deser_data_val_o <= 1'b0;
      if (data_val_i && complete) begin
        deser_data_o     <= asm_with_bit;
        deser_len_o      <= LW'(cnt) + LW'(1);
        deser_data_val_o <= 1'b1;
      end
    end
  end

  assign busy_o = (cnt != '0);

endmodule
